// File: rtl/rice_preprocessing_if.sv
// rtl/rice_preprocessing_if.sv - control, compressed-word and decoded-symbol signals of the Rice front end
interface rice_preprocessing_if;
  logic        first;
  logic        start;
  logic        stop;
  logic        wren;
  logic        rden;
  logic [4:0]  n;
  logic [4:0]  j;
  logic [4:0]  k;
  logic [31:0] data;
  logic        datavalid;
  logic [9:0]  symbol;
  logic [4:0]  fscodes;
  logic [4:0]  kcodes;
  logic        symvalid;
  logic        blkdone;

  modport master (
    output first, start, stop, wren, rden, n, j, k, data, datavalid,
    input  symbol, fscodes, kcodes, symvalid, blkdone
  );

  modport slave (
    input  first, start, stop, wren, rden, n, j, k, data, datavalid,
    output symbol, fscodes, kcodes, symvalid, blkdone
  );
endinterface

// File: rtl/rice_preprocessing.sv
// rtl/rice_preprocessing.sv - Rice decoder front end: word FIFO, MSB-first unpacker, FS/split field splitter
// Reference-sample decoding is compiled in only when RICE_REF_SAMPLE_EN is defined.
module rice_preprocessing #(
  parameter int FIFO_DEPTH = 4,
  parameter int DW         = 32
) (
  input logic                 clk1,
  input logic                 reset,
  rice_preprocessing_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REF, S_FS, S_SPLIT, S_EMIT} state_t;
  state_t r_state, w_next;

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic [DW-1:0] r_sr;
  logic [5:0]    r_bitcnt;
  logic [4:0]    r_j, r_cnt, r_fs, r_kbits;
  logic [2:0]    r_k;
  logic [3:0]    r_rem;
  logic [9:0]    r_symbol;
  logic [4:0]    r_fscodes, r_kcodes;

  logic       w_empty, w_full, w_pop, w_push, w_bit, w_consume, w_emit, w_last;
  logic [4:0] w_cnt_inc;
  logic [9:0] w_shifted, w_sym;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // A word is only loaded once the previous one is fully consumed; stop blocks the load so the FIFO keeps it.
  assign w_pop     = !bus.stop && bus.rden && !w_empty && (r_bitcnt == 6'd0);
  assign w_push    = bus.wren && bus.datavalid && (!w_full || w_pop);
  assign w_bit     = r_sr[DW-1];
  assign w_consume = !bus.stop && (r_bitcnt != 6'd0) &&
                     (r_state == S_REF || r_state == S_FS || r_state == S_SPLIT);
  assign w_emit    = !bus.stop && (r_state == S_EMIT);
  assign w_cnt_inc = r_cnt + 5'd1;
  assign w_last    = (w_cnt_inc == r_j);
  assign w_shifted = {5'd0, r_fs} << r_k;

`ifdef RICE_REF_SAMPLE_EN
  logic [9:0] r_acc;
  logic       r_isref;
  logic [3:0] w_n_clamp;
  assign w_n_clamp = (bus.n == 5'd0) ? 4'd1 : (bus.n > 5'd10) ? 4'd10 : bus.n[3:0];
  assign w_sym     = r_isref ? r_acc : (w_shifted | {5'd0, r_kbits});
`else
  logic w_unused_ref;
  assign w_unused_ref = ^{bus.first, bus.n};
  assign w_sym        = w_shifted | {5'd0, r_kbits};
`endif

  assign bus.symvalid = w_emit;
  assign bus.blkdone  = w_emit && w_last;
  assign bus.symbol   = w_emit ? w_sym   : r_symbol;
  assign bus.fscodes  = w_emit ? r_fs    : r_fscodes;
  assign bus.kcodes   = w_emit ? r_kbits : r_kcodes;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
`ifdef RICE_REF_SAMPLE_EN
          w_next = bus.first ? S_REF : S_FS;
`else
          w_next = S_FS;
`endif
        end
`ifdef RICE_REF_SAMPLE_EN
        S_REF:   if (w_consume && r_rem == 4'd1) w_next = S_EMIT;
`endif
        S_FS:    if (w_consume && w_bit) w_next = (r_k == 3'd0) ? S_EMIT : S_SPLIT;
        S_SPLIT: if (w_consume && r_rem == 4'd1) w_next = S_EMIT;
        S_EMIT:  w_next = w_last ? S_IDLE : S_FS;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.data;
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_sr      <= '0;
      r_bitcnt  <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_fs      <= '0;
      r_kbits   <= '0;
      r_rem     <= '0;
      r_symbol  <= '0;
      r_fscodes <= '0;
      r_kcodes  <= '0;
`ifdef RICE_REF_SAMPLE_EN
      r_acc     <= '0;
      r_isref   <= 1'b0;
`endif
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (bus.stop) begin
        r_bitcnt <= 6'd0;
      end else if (w_pop) begin
        r_sr     <= r_mem[r_rptr[AW-1:0]];
        r_bitcnt <= 6'(DW);
      end else if (w_consume) begin
        r_sr     <= {r_sr[DW-2:0], 1'b0};
        r_bitcnt <= r_bitcnt - 6'd1;
      end
      if (!bus.stop) begin
        case (r_state)
          S_IDLE: if (bus.start) begin
            r_j     <= (bus.j == 5'd0) ? 5'd1 : bus.j;
            r_k     <= (bus.k > 5'd5) ? 3'd5 : bus.k[2:0];
            r_cnt   <= '0;
            r_fs    <= '0;
            r_kbits <= '0;
`ifdef RICE_REF_SAMPLE_EN
            r_rem   <= w_n_clamp;
            r_isref <= bus.first;
            r_acc   <= '0;
`endif
          end
`ifdef RICE_REF_SAMPLE_EN
          S_REF: if (w_consume) begin
            r_acc <= {r_acc[8:0], w_bit};
            r_rem <= r_rem - 4'd1;
          end
`endif
          S_FS: if (w_consume) begin
            if (!w_bit) begin
              if (r_fs != 5'd31) r_fs <= r_fs + 5'd1;
            end else begin
              r_rem <= {1'b0, r_k};
            end
          end
          S_SPLIT: if (w_consume) begin
            r_kbits <= {r_kbits[3:0], w_bit};
            r_rem   <= r_rem - 4'd1;
          end
          S_EMIT: begin
            r_cnt     <= w_cnt_inc;
            r_symbol  <= w_sym;
            r_fscodes <= r_fs;
            r_kcodes  <= r_kbits;
            r_fs      <= '0;
            r_kbits   <= '0;
`ifdef RICE_REF_SAMPLE_EN
            r_isref   <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rice_preprocessing.sv
// tb/tb_rice_preprocessing.sv - self-checking bench for rice_preprocessing with an encoder-side reference model
module tb_rice_preprocessing;
  logic clk1  = 1'b0;
  logic reset = 1'b0;

  rice_preprocessing_if bus ();

  rice_preprocessing #(.FIFO_DEPTH(4), .DW(32)) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

`ifdef RICE_REF_SAMPLE_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  typedef struct {
    logic [9:0] sym;
    logic [4:0] fs;
    logic [4:0] kc;
    logic       bd;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  logic bits_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic add_exp(input int sym, input int fs, input int kc, input bit bd);
    exp_t e;
    e.sym = 10'(sym);
    e.fs  = 5'(fs);
    e.kc  = 5'(kc);
    e.bd  = bd;
    exp_q.push_back(e);
  endtask

  always @(negedge clk1) begin
    if (reset) begin
      if (bus.blkdone && !bus.symvalid) begin
        checks++;
        errors++;
        $display("FAIL blkdone_alone: actual blkdone=1 symvalid=0 required symvalid=1");
      end
      if (bus.symvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol: actual symbol %0d fscodes %0d required no strobe",
                   bus.symbol, bus.fscodes);
        end else begin
          cmp_e = exp_q.pop_front();
          check("symbol",  32'(bus.symbol),  32'(cmp_e.sym));
          check("fscodes", 32'(bus.fscodes), 32'(cmp_e.fs));
          check("kcodes",  32'(bus.kcodes),  32'(cmp_e.kc));
          check("blkdone", 32'(bus.blkdone), 32'(cmp_e.bd));
        end
      end
    end
  end

  task automatic tick(input int c);
    repeat (c) @(posedge clk1);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus.data      = w;
    bus.wren      = 1'b1;
    bus.datavalid = 1'b1;
    tick(1);
    bus.wren      = 1'b0;
    bus.datavalid = 1'b0;
    bus.data      = $urandom;
  endtask

  task automatic cfg(input int n, input int j, input int k, input bit first);
    bus.n     = 5'(n);
    bus.j     = 5'(j);
    bus.k     = 5'(k);
    bus.first = first;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(2);
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    tick(1);
    bus.stop  = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick(1);
      c++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: actual %0d symbols outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_symbol"},   32'(bus.symbol),   0);
    check({tag, "_fscodes"},  32'(bus.fscodes),  0);
    check({tag, "_kcodes"},   32'(bus.kcodes),   0);
    check({tag, "_symvalid"}, 32'(bus.symvalid), 0);
    check({tag, "_blkdone"},  32'(bus.blkdone),  0);
  endtask

  // Encode three random blocks into a bitstream, deriving the expected symbols from the samples chosen.
  task automatic random_round();
    int nr, jr, kr, ne, je, ke, z, kb, v, fs, pad, left;
    bit fr, use_ref, last;
    logic [31:0] w;
    nr = $urandom_range(0, 15);
    jr = $urandom_range(0, 10);
    kr = $urandom_range(0, 7);
    fr = 1'($urandom_range(0, 1));
    ne = (nr < 1) ? 1 : ((nr > 10) ? 10 : nr);
    je = (jr == 0) ? 1 : jr;
    ke = (kr > 5) ? 5 : kr;
    use_ref = REF_EN && fr;
    bits_q.delete();
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < je; s++) begin
        last = (s == je - 1);
        if (s == 0 && use_ref) begin
          v = $urandom_range(0, (1 << ne) - 1);
          for (int i = ne - 1; i >= 0; i--) bits_q.push_back(v[i]);
          add_exp(v, 0, 0, last);
        end else begin
          z  = ($urandom_range(0, 7) == 0) ? $urandom_range(31, 34) : $urandom_range(0, 6);
          kb = (ke == 0) ? 0 : $urandom_range(0, (1 << ke) - 1);
          repeat (z) bits_q.push_back(1'b0);
          bits_q.push_back(1'b1);
          for (int i = ke - 1; i >= 0; i--) bits_q.push_back(kb[i]);
          fs = (z > 31) ? 31 : z;
          add_exp(((fs << ke) | kb) & 1023, fs, kb, last);
        end
      end
    end
    pad = (32 - (bits_q.size() % 32)) % 32;
    // Zero padding starts a further block; with a reference sample enabled it may yield zero references.
    if (use_ref) begin
      left = pad;
      while (left >= ne) begin
        add_exp(0, 0, 0, je == 1);
        left -= ne;
        if (je != 1) break;
      end
    end
    repeat (pad) bits_q.push_back(1'b0);
    cfg(nr, jr, kr, fr);
    bus.start = 1'b1;
    while (bits_q.size() > 0) begin
      for (int i = 31; i >= 0; i--) w[i] = bits_q.pop_front();
      push(w);
      bus.wren = 1'b1;
      tick(1);
      bus.wren = 1'b0;
      tick(97);
    end
    drain("round_drain", 4000);
    tick(40);
    do_stop();
  endtask

  initial begin
    bus.first = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.wren  = 1'b0; bus.rden  = 1'b1; bus.datavalid = 1'b0;
    bus.n = '0; bus.j = '0; bus.k = '0; bus.data = '0;
    tick(3);
    check_outputs_zero("reset");
    reset = 1'b1;
    tick(2);

    cfg(8, 10, 1, 0);
    add_exp(8, 4, 0, 0);  add_exp(0, 0, 0, 0); add_exp(6, 3, 0, 0);
    add_exp(6, 3, 0, 0);  add_exp(8, 4, 0, 0); add_exp(0, 0, 0, 0);
    add_exp(11, 5, 1, 0);
    push(32'h0A108281);
    push(32'h80000000);
    pulse_start();
    drain("spanning_words", 400);
    tick(40);
    do_stop();

    cfg(8, 1, 0, 0);
    add_exp(31, 31, 0, 1);
    push(32'h00000001);
    pulse_start();
    drain("fs_saturation", 200);
    tick(10);
    do_stop();

`ifdef RICE_REF_SAMPLE_EN
    cfg(8, 2, 0, 1);
    add_exp(8'hA5, 0, 0, 0);
    add_exp(0, 0, 0, 1);
    push(32'hA5800000);
    pulse_start();
    drain("reference_sample", 200);
    tick(40);
    do_stop();
    bus.first = 1'b0;
`endif

    cfg(8, 1, 0, 0);
    bus.rden = 1'b0;
    pulse_start();
    push(32'h10000000);
    bus.rden = 1'b1;
    tick(4);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    tick(10);
    add_exp(1, 1, 0, 1);
    push(32'h40000000);
    pulse_start();
    drain("after_stop", 200);
    do_stop();

    cfg(8, 1, 0, 0);
    bus.rden = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h00000001);
    push(32'h40000000);
    for (int i = 0; i < 4; i++) add_exp(31, 31, 0, 1);
    bus.start = 1'b1;
    bus.rden  = 1'b1;
    drain("fifo_full_drop", 600);
    tick(200);
    do_stop();

    cfg(8, 3, 0, 0);
    bus.rden = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h00000001);
    bus.start = 1'b1;
    bus.rden  = 1'b1;
    tick(1);
    bus.rden = 1'b0;
    tick(10);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    tick(2);
    reset = 1'b1;
    cfg(8, 1, 0, 0);
    bus.rden = 1'b1;
    tick(200);
    add_exp(1, 1, 0, 1);
    push(32'h40000000);
    drain("fifo_cleared", 200);
    do_stop();

    for (int r = 0; r < 10; r++) random_round();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
